cpu_param: RTL and testbench
============================

// Module: cpu_param
// PURPOSE
//  Parametrised single-issue CPU core: 32-bit fixed instruction word, DATA_W-bit datapath, 2^REG_ADDR_W regs.
//  Adds j/beq, instruction-memory stall handshake (BUSYWAIT), illegal-opcode flag, optional iterative multiply.
//  Sits between instruction memory (driven by PC) and testbench/top; register file is internal.
// PARAMETERS
//  DATA_W      8   datapath and register width (>=8)
//  REG_ADDR_W  3   register index width; 2^REG_ADDR_W registers
//  PC_W        32  program counter width
// PORTS
//  CLK          in   1           single clock, all state updates on posedge
//  RESET        in   1           synchronous, active-high
//  INSTRUCTION  in   32          {opcode[31:24], rd/offset[23:16], rt[15:8], rs/imm[7:0]}
//  BUSYWAIT     in   1           high = instruction not yet valid; core holds all state
//  PC           out  PC_W        address of current instruction
//  ILLEGAL      out  1           1-cycle pulse on retiring an undefined opcode
//  BUSY         out  1           high while a multi-cycle op is in progress
//  DBG_ADDR     in   REG_ADDR_W  debug register read index
//  DBG_DATA     out  DATA_W      combinational read of reg[DBG_ADDR]
// BEHAVIOUR
//  Reset (RESET high at posedge): PC=0, all regs=0, ILLEGAL=0, BUSY=0, FSM->EXEC; aborts any op in flight.
//  Register indices = low REG_ADDR_W bits of rd/rt/rs fields.
//  Opcodes: 00 loadi rd=sext(imm) | 01 mov rd=rs | 02 add rd=rt+rs | 03 sub rd=rt-rs (two's compl)
//   04 and | 05 or | 06 j | 07 beq (rt==rs) | 08 mult (CPU_MUL_EN only); all others illegal.
//  Arithmetic modulo 2^DATA_W; imm sign-extended 8->DATA_W.
//  EXEC, BUSYWAIT=0: one cycle per instruction; reg write and PC update on same posedge.
//   Next PC = PC+4; j / taken beq: PC+4+(sext(offset[23:16])<<2), wraps modulo 2^PC_W.
//   j, beq, illegal: no register write. Illegal: PC+4, ILLEGAL=1 for that one cycle.
//  BUSYWAIT=1 at posedge: PC, regs, ILLEGAL(=0) held; no write. Resumes the cycle BUSYWAIT drops.
//  Reg writes to same reg read in same instruction: read sees old value (write at posedge).
//  FSM: EXEC -> MUL_BUSY (mult accepted) -> EXEC (after DATA_W cycles). Only EXEC exists without macro.
//  DBG_DATA purely combinational, no side effects.
// CONFIGURATION
//  CPU_MUL_EN defined: opcode 08 = mult rd = low DATA_W bits of rt*rs, shift-add, one bit/cycle.
//   Accept cycle latches operands, BUSY=1 next cycle; DATA_W cycles later rd written, PC+=4, BUSY=0.
//   BUSYWAIT ignored while BUSY; INSTRUCTION must stay stable (PC unchanged). RESET mid-op: rd unwritten.
//  CPU_MUL_EN undefined: opcode 08 illegal; BUSY tied 0; no multiplier logic.
// STRUCTURE
//  Package cpu_pkg: opcode constants OP_LOADI..OP_MULT, ALU op enum, FSM state enum, field bit-range consts.
//  Sub-module reg_file_param (2 async read + debug read, 1 sync write, sync reset), params DATA_W, REG_ADDR_W.
//  ALU, next-PC logic, decode, multiplier in cpu_param itself.
// TESTING (DATA_W=8 unless noted)
//  T1 reset; loadi r1,5; loadi r2,3; add r3,r1,r2 -> r3=0x08, PC=12 after 3 cycles.
//  T2 sub r4,r2,r1 (3-5) -> r4=0xFE; loadi r5,0x80 with DATA_W=16 -> r5=0xFF80.
//  T3 beq r1,r1 off=-2 at PC=16 -> PC=12; beq r1,r2 -> PC=20; j off=+1 at PC=20 -> PC=28.
//  T4 BUSYWAIT high 3 cycles over add -> PC/regs frozen; retires on 4th cycle, ILLEGAL stays 0.
//  T5 opcode 0xFF -> ILLEGAL=1 exactly one cycle, no reg change, PC+4; RESET mid-stream -> PC=0, regs 0.
//  T6 CPU_MUL_EN: mult r6,r1,r2 -> BUSY 8 cycles, r6=0x0F, PC+4 once; RESET at cycle 4 -> r6=0;
//     macro off: opcode 08 -> ILLEGAL pulse, BUSY never high.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for cpu_param: opcodes, instruction field positions, ALU/FSM enums and the decoder.
package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_MULT  = 8'h08;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 24;
    localparam int RD_HI  = 23;
    localparam int RD_LO  = 16;
    localparam int RT_HI  = 15;
    localparam int RT_LO  = 8;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 0;

    typedef enum logic [2:0] {
        ALU_IMM,
        ALU_MOV,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR
    } alu_op_e;

    typedef enum logic {
        ST_EXEC,
        ST_MUL_BUSY
    } cpu_state_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    reg_we;
        logic    jump;
        logic    branch;
        logic    mult;
        logic    illegal;
    } dec_t;

    // mul_en folds the multiplier build option into decode: without it 08 is just another illegal opcode.
    function automatic dec_t decode(input logic [7:0] opc, input logic mul_en);
        dec_t d;
        d = '0;
        case (opc)
            OP_LOADI: begin d.alu_op = ALU_IMM; d.reg_we = 1'b1; end
            OP_MOV:   begin d.alu_op = ALU_MOV; d.reg_we = 1'b1; end
            OP_ADD:   begin d.alu_op = ALU_ADD; d.reg_we = 1'b1; end
            OP_SUB:   begin d.alu_op = ALU_SUB; d.reg_we = 1'b1; end
            OP_AND:   begin d.alu_op = ALU_AND; d.reg_we = 1'b1; end
            OP_OR:    begin d.alu_op = ALU_OR;  d.reg_we = 1'b1; end
            OP_J:     d.jump = 1'b1;
            OP_BEQ:   d.branch = 1'b1;
            OP_MULT:  begin
                if (mul_en) d.mult = 1'b1;
                else        d.illegal = 1'b1;
            end
            default:  d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/reg_file_param.sv
// Register file: two asynchronous operand reads, one debug read, one synchronous write, synchronous clear.
module reg_file_param
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0]     rd_data_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_b,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam int NREGS = 1 << REG_ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs;

    always_ff @(posedge CLK) begin
        if (RESET)      regs <= '0;
        else if (wr_en) regs[wr_addr] <= wr_data;
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
    assign dbg_data  = regs[dbg_addr];

endmodule

// File: rtl/cpu_param.sv
// Single-issue parametrised CPU core with j/beq, fetch stall and illegal-opcode flag.
// Define CPU_MUL_EN to add the iterative shift-add multiplier (opcode 08).
module cpu_param
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter int PC_W       = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           INSTRUCTION,
    input  logic                  BUSYWAIT,
    output logic [PC_W-1:0]       PC,
    output logic                  ILLEGAL,
    output logic                  BUSY,
    input  logic [REG_ADDR_W-1:0] DBG_ADDR,
    output logic [DATA_W-1:0]     DBG_DATA
);

`ifdef CPU_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    logic [7:0]            opc, imm8, off8;
    logic [REG_ADDR_W-1:0] rd_a, rt_a, rs_a;
    logic [DATA_W-1:0]     rt_d, rs_d, imm_x, alu_y;
    logic [PC_W-1:0]       pc_seq, pc_tgt;
    dec_t                  dec;
    logic                  exec_go, take;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  mul_done;
    logic                  unused_fields;

    assign opc  = INSTRUCTION[OPC_HI:OPC_LO];
    assign off8 = INSTRUCTION[RD_HI:RD_LO];
    assign imm8 = INSTRUCTION[RS_HI:RS_LO];
    assign rd_a = INSTRUCTION[RD_LO +: REG_ADDR_W];
    assign rt_a = INSTRUCTION[RT_LO +: REG_ADDR_W];
    assign rs_a = INSTRUCTION[RS_LO +: REG_ADDR_W];
    assign unused_fields = ^INSTRUCTION[RT_HI:RT_LO];

    assign dec   = decode(opc, MUL_EN);
    assign imm_x = DATA_W'($signed(imm8));

    reg_file_param #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_rf (
        .CLK       (CLK),
        .RESET     (RESET),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rt_a),
        .rd_data_a (rt_d),
        .rd_addr_b (rs_a),
        .rd_data_b (rs_d),
        .dbg_addr  (DBG_ADDR),
        .dbg_data  (DBG_DATA)
    );

    always_comb begin
        alu_y = '0;
        case (dec.alu_op)
            ALU_IMM: alu_y = imm_x;
            ALU_MOV: alu_y = rs_d;
            ALU_ADD: alu_y = rt_d + rs_d;
            ALU_SUB: alu_y = rt_d - rs_d;
            ALU_AND: alu_y = rt_d & rs_d;
            ALU_OR:  alu_y = rt_d | rs_d;
            default: alu_y = '0;
        endcase
    end

    // Branch offset counts words relative to the following instruction.
    assign pc_seq = PC + PC_W'(4);
    assign pc_tgt = pc_seq + (PC_W'($signed(off8)) << 2);
    assign take   = dec.jump | (dec.branch & (rt_d == rs_d));

`ifdef CPU_MUL_EN
    localparam int CNT_W = $clog2(DATA_W) + 1;

    cpu_state_e            state, state_nx;
    logic [DATA_W-1:0]     mul_acc, mul_mcand, mul_mplier, mul_sum;
    logic [REG_ADDR_W-1:0] mul_rd;
    logic [CNT_W-1:0]      mul_cnt;
    logic                  mul_last;

    assign mul_last = (mul_cnt == CNT_W'(DATA_W - 1));
    assign mul_sum  = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_EXEC;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_EXEC:     if (!BUSYWAIT && dec.mult) state_nx = ST_MUL_BUSY;
            ST_MUL_BUSY: if (mul_last) state_nx = ST_EXEC;
            default:     state_nx = ST_EXEC;
        endcase
    end

    always_comb begin
        exec_go  = (state == ST_EXEC) && !BUSYWAIT;
        BUSY     = (state == ST_MUL_BUSY);
        mul_done = (state == ST_MUL_BUSY) && mul_last;
    end

    // One multiplier bit per cycle; the final partial sum is written straight from mul_sum.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_rd     <= '0;
            mul_cnt    <= '0;
        end else if (exec_go && dec.mult) begin
            mul_acc    <= '0;
            mul_mcand  <= rt_d;
            mul_mplier <= rs_d;
            mul_rd     <= rd_a;
            mul_cnt    <= '0;
        end else if (BUSY) begin
            mul_acc    <= mul_sum;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + CNT_W'(1);
        end
    end

    assign wr_en   = (exec_go && dec.reg_we) || mul_done;
    assign wr_addr = mul_done ? mul_rd  : rd_a;
    assign wr_data = mul_done ? mul_sum : alu_y;
`else
    assign exec_go  = !BUSYWAIT;
    assign BUSY     = 1'b0;
    assign mul_done = 1'b0;
    assign wr_en    = exec_go && dec.reg_we;
    assign wr_addr  = rd_a;
    assign wr_data  = alu_y;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            PC      <= '0;
            ILLEGAL <= 1'b0;
        end else begin
            ILLEGAL <= exec_go && dec.illegal;
            if (exec_go && !dec.mult) PC <= take ? pc_tgt : pc_seq;
            else if (mul_done)        PC <= pc_seq;
        end
    end

endmodule

// File: tb/tb_cpu_param.sv
// Directed + randomized bench for cpu_param against an instruction-level reference model.
module tb_cpu_param;

    localparam int W = 8;
    localparam int unsigned MASK = 32'hFF;

    logic        CLK = 1'b0;
    logic        RESET, BUSYWAIT;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;
    logic        ILLEGAL, BUSY;
    logic [2:0]  DBG_ADDR;
    logic [7:0]  DBG_DATA;

    logic [31:0] INS16;
    logic [31:0] PC16;
    logic        ILL16, BUSY16;
    logic [2:0]  DBG_ADDR16;
    logic [15:0] DBG_DATA16;

    int checks = 0;
    int errors = 0;

    int unsigned regs_m [8];
    logic [31:0] pc_m;
    bit          ill_m;
    int          mul_left;
    int unsigned mul_a, mul_b;
    int          mul_rd;

    always #10 CLK = ~CLK;

    cpu_param #(.DATA_W(8), .REG_ADDR_W(3), .PC_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT),
        .PC(PC), .ILLEGAL(ILLEGAL), .BUSY(BUSY), .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
    );

    cpu_param #(.DATA_W(16), .REG_ADDR_W(3), .PC_W(32)) dut16 (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INS16), .BUSYWAIT(1'b0),
        .PC(PC16), .ILLEGAL(ILL16), .BUSY(BUSY16), .DBG_ADDR(DBG_ADDR16), .DBG_DATA(DBG_DATA16)
    );

    function automatic int sx8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] c);
        return {op, a, b, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction-level reference: what one clock edge does to the architectural state.
    task automatic model_step(input logic rst, input logic bw, input logic [31:0] ins);
        logic [7:0]  op;
        int          rd, rt, rs;
        logic [31:0] nxt;
        if (rst) begin
            pc_m = '0;
            foreach (regs_m[i]) regs_m[i] = 0;
            ill_m = 0;
            mul_left = 0;
            return;
        end
        ill_m = 0;
        if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) begin
                regs_m[mul_rd] = (mul_a * mul_b) & MASK;
                pc_m = pc_m + 4;
            end
            return;
        end
        if (bw) return;
        op  = ins[31:24];
        rd  = int'(ins[18:16]);
        rt  = int'(ins[10:8]);
        rs  = int'(ins[2:0]);
        nxt = pc_m + 4;
        case (op)
            8'h00: regs_m[rd] = sx8(ins[7:0]) & MASK;
            8'h01: regs_m[rd] = regs_m[rs];
            8'h02: regs_m[rd] = (regs_m[rt] + regs_m[rs]) & MASK;
            8'h03: regs_m[rd] = (regs_m[rt] - regs_m[rs]) & MASK;
            8'h04: regs_m[rd] = regs_m[rt] & regs_m[rs];
            8'h05: regs_m[rd] = regs_m[rt] | regs_m[rs];
            8'h06: nxt = pc_m + 4 + sx8(ins[23:16]) * 4;
            8'h07: if (regs_m[rt] == regs_m[rs]) nxt = pc_m + 4 + sx8(ins[23:16]) * 4;
`ifdef CPU_MUL_EN
            8'h08: begin
                mul_left = W;
                mul_rd   = rd;
                mul_a    = regs_m[rt];
                mul_b    = regs_m[rs];
                nxt      = pc_m;
            end
`endif
            default: ill_m = 1;
        endcase
        pc_m = nxt;
    endtask

    task automatic peek(input int i, output logic [7:0] v);
        DBG_ADDR = 3'(i);
        #1;
        v = DBG_DATA;
    endtask

    task automatic check_all();
        logic [7:0] v;
        chk("pc", PC, pc_m);
        chk("illegal", {31'b0, ILLEGAL}, {31'b0, ill_m});
        chk("busy", {31'b0, BUSY}, {31'b0, mul_left > 0});
        for (int i = 0; i < 8; i++) begin
            peek(i, v);
            chk($sformatf("r%0d", i), {24'b0, v}, regs_m[i]);
        end
    endtask

    task automatic cycle(input logic rst, input logic bw, input logic [31:0] ins);
        RESET = rst;
        BUSYWAIT = bw;
        INSTRUCTION = ins;
        @(posedge CLK);
        model_step(rst, bw, ins);
        #2;
        check_all();
    endtask

    function automatic logic [31:0] rand_ins();
        int r;
        logic [7:0] op;
        r = $urandom_range(0, 19);
        if (r < 17)      op = 8'($urandom_range(0, 7));
        else if (r < 19) op = 8'h08;
        else             op = 8'($urandom_range(9, 255));
        return {op, 8'($urandom), 8'($urandom), 8'($urandom)};
    endfunction

    initial begin
        logic [7:0]  v;
        logic [31:0] pc_save, ins;
        logic        rst, bw;

        DBG_ADDR = '0;
        DBG_ADDR16 = '0;
        INS16 = 32'h0100_0000;

        // T1: reset then loadi/loadi/add; the 16-bit core runs a sign-extension sequence alongside.
        cycle(1'b1, 1'b0, 32'h0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_busy", {31'b0, BUSY}, 32'h0);
        INS16 = mk(8'h00, 8'h05, 8'h00, 8'h80);
        cycle(1'b0, 1'b0, mk(8'h00, 8'h01, 8'h00, 8'h05));
        INS16 = mk(8'h00, 8'h06, 8'h00, 8'h7F);
        cycle(1'b0, 1'b0, mk(8'h00, 8'h02, 8'h00, 8'h03));
        INS16 = mk(8'h02, 8'h07, 8'h05, 8'h06);
        cycle(1'b0, 1'b0, mk(8'h02, 8'h03, 8'h01, 8'h02));
        INS16 = 32'h0100_0000;
        peek(3, v);
        chk("T1_r3", {24'b0, v}, 32'h08);
        chk("T1_pc", PC, 32'd12);
        DBG_ADDR16 = 3'd5; #1; chk("T2_w16_r5", {16'b0, DBG_DATA16}, 32'hFF80);
        DBG_ADDR16 = 3'd6; #1; chk("T2_w16_r6", {16'b0, DBG_DATA16}, 32'h007F);
        DBG_ADDR16 = 3'd7; #1; chk("T2_w16_r7", {16'b0, DBG_DATA16}, 32'hFFFF);

        // T2: sub wraps below zero.
        cycle(1'b0, 1'b0, mk(8'h03, 8'h04, 8'h02, 8'h01));
        peek(4, v);
        chk("T2_r4", {24'b0, v}, 32'hFE);

        // T3: taken beq backwards, filler, untaken beq, forward jump.
        cycle(1'b0, 1'b0, mk(8'h07, 8'hFE, 8'h01, 8'h01));
        chk("T3_beq_taken", PC, 32'd12);
        cycle(1'b0, 1'b0, mk(8'h01, 8'h07, 8'h00, 8'h03));
        cycle(1'b0, 1'b0, mk(8'h07, 8'h05, 8'h01, 8'h02));
        chk("T3_beq_not", PC, 32'd20);
        cycle(1'b0, 1'b0, mk(8'h06, 8'h01, 8'h00, 8'h00));
        chk("T3_j", PC, 32'd28);

        // T4: three stalled edges, then the add retires.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, mk(8'h02, 8'h00, 8'h01, 8'h02));
            chk("T4_pc_held", PC, 32'd28);
        end
        cycle(1'b0, 1'b0, mk(8'h02, 8'h00, 8'h01, 8'h02));
        peek(0, v);
        chk("T4_r0", {24'b0, v}, 32'h08);
        chk("T4_pc", PC, 32'd32);

        // T5: illegal opcode pulse, then reset in mid-stream.
        cycle(1'b0, 1'b0, 32'hFF12_3456);
        chk("T5_ill_hi", {31'b0, ILLEGAL}, 32'h1);
        chk("T5_pc", PC, 32'd36);
        cycle(1'b0, 1'b0, mk(8'h05, 8'h05, 8'h01, 8'h02));
        chk("T5_ill_lo", {31'b0, ILLEGAL}, 32'h0);
        cycle(1'b1, 1'b0, mk(8'h00, 8'h01, 8'h00, 8'h55));
        chk("T5_rst_pc", PC, 32'h0);
        peek(5, v);
        chk("T5_rst_r5", {24'b0, v}, 32'h0);

        // T6: multiply (or its illegal behaviour when the multiplier is not built).
        cycle(1'b0, 1'b0, mk(8'h00, 8'h01, 8'h00, 8'h05));
        cycle(1'b0, 1'b0, mk(8'h00, 8'h02, 8'h00, 8'h03));
        pc_save = PC;
`ifdef CPU_MUL_EN
        cycle(1'b0, 1'b0, mk(8'h08, 8'h06, 8'h01, 8'h02));
        chk("T6_busy_acc", {31'b0, BUSY}, 32'h1);
        for (int k = 0; k < W; k++) begin
            cycle(1'b0, 1'(k % 2), mk(8'h08, 8'h06, 8'h01, 8'h02));
            if (k < W - 1) chk("T6_pc_hold", PC, pc_save);
        end
        chk("T6_busy_done", {31'b0, BUSY}, 32'h0);
        peek(6, v);
        chk("T6_r6", {24'b0, v}, 32'h0F);
        chk("T6_pc", PC, pc_save + 32'd4);
        cycle(1'b0, 1'b0, mk(8'h08, 8'h07, 8'h01, 8'h02));
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, mk(8'h08, 8'h07, 8'h01, 8'h02));
        cycle(1'b1, 1'b0, mk(8'h08, 8'h07, 8'h01, 8'h02));
        peek(7, v);
        chk("T6_rst_r7", {24'b0, v}, 32'h0);
        chk("T6_rst_busy", {31'b0, BUSY}, 32'h0);
`else
        cycle(1'b0, 1'b0, mk(8'h08, 8'h06, 8'h01, 8'h02));
        chk("T6_ill", {31'b0, ILLEGAL}, 32'h1);
        chk("T6_busy", {31'b0, BUSY}, 32'h0);
        chk("T6_pc", PC, pc_save + 32'd4);
        peek(6, v);
        chk("T6_r6", {24'b0, v}, 32'h0);
`endif

        // Random instruction stream with stalls and occasional resets.
        ins = rand_ins();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            bw  = ($urandom_range(0, 3) == 0);
            if (mul_left == 0) ins = rand_ins();
            cycle(rst, bw, ins);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
